// File: rtl/inj_sched.sv
// Angle-scheduled multi-channel fuel injector driver: per-channel start-angle match,
// batch/sequential firing, latched pulse length, minimum off-time and overlap flagging.
module inj_sched #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 16,
    parameter int CNT_W   = 32,
    parameter int MIN_OFF = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    trigger,
    input  logic [PHASE_W-1:0]      eng_phase,
    input  logic                    mode,
    input  logic [N_CH*PHASE_W-1:0] ch_phase,
    input  logic [CNT_W-1:0]        on_cycles,
    output logic [N_CH-1:0]         inj_out,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         overlap_err
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        RECOVER
    } state_e;

    localparam bit             NO_RECOVER = (MIN_OFF == 0);
    localparam logic [CNT_W-1:0] REC_LAST = (MIN_OFF > 0) ? CNT_W'(MIN_OFF - 1) : '0;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] len_q   [N_CH];
    logic [CNT_W-1:0] len_d   [N_CH];

    logic [N_CH-1:0] on_q, on_d;
    logic [N_CH-1:0] tg_q, tg_d;
    logic [N_CH-1:0] ovl_q, ovl_d;
    logic [N_CH-1:0] busy_q, busy_d;
    logic [N_CH-1:0] match, fire, last;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            len_d[i]   = len_q[i];
            on_d[i]    = on_q[i];
            tg_d[i]    = tg_q[i];
            ovl_d[i]   = 1'b0;

            match[i] = trigger && (eng_phase == ch_phase[i*PHASE_W +: PHASE_W])
                       && (on_cycles != '0);
            fire[i]  = match[i] && (!mode || tg_q[i]);
            if (match[i]) tg_d[i] = !tg_q[i];

            // Final busy cycle: the channel re-arms on this same edge, so a request
            // arriving now starts the next pulse instead of being flagged.
            last[i] = (state_q[i] == ON && cnt_q[i] == len_q[i] && NO_RECOVER)
                      || (state_q[i] == RECOVER && cnt_q[i] == REC_LAST);

            case (state_q[i])
                ON: begin
                    if (cnt_q[i] == len_q[i]) begin
                        on_d[i]    = 1'b0;
                        cnt_d[i]   = '0;
                        state_d[i] = NO_RECOVER ? IDLE : RECOVER;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (cnt_q[i] == REC_LAST) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase

            if (fire[i]) begin
                if (state_q[i] == IDLE || last[i]) begin
                    len_d[i]   = on_cycles;
                    cnt_d[i]   = CNT_W'(1);
                    on_d[i]    = 1'b1;
                    state_d[i] = ON;
                end else begin
                    ovl_d[i] = 1'b1;
                end
            end

            busy_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                len_q[i]   <= '0;
            end
            on_q   <= '0;
            tg_q   <= '0;
            ovl_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                len_q[i]   <= len_d[i];
            end
            on_q   <= on_d;
            tg_q   <= tg_d;
            ovl_q  <= ovl_d;
            busy_q <= busy_d;
        end
    end

    assign inj_out     = on_q & {N_CH{en}};
    assign busy        = busy_q;
    assign overlap_err = ovl_q;

endmodule

// File: tb/tb_inj_sched.sv
// Randomized bench for inj_sched: two instances (MIN_OFF=4 and MIN_OFF=0) checked
// against a pulse-interval model that tracks start time, length and re-arm time.
module tb_inj_sched;

    localparam int N_CH = 4;
    localparam int PW   = 16;
    localparam int CW   = 32;
    localparam int N_CYC = 4000;

    logic                 clk = 1'b0;
    logic                 rst, en, trigger, mode;
    logic [PW-1:0]        eng_phase;
    logic [N_CH*PW-1:0]   ch_phase;
    logic [CW-1:0]        on_cycles;
    logic [N_CH-1:0]      inj_a, busy_a, ovl_a;
    logic [N_CH-1:0]      inj_b, busy_b, ovl_b;

    always #5 clk = ~clk;

    inj_sched #(.N_CH(N_CH), .PHASE_W(PW), .CNT_W(CW), .MIN_OFF(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .eng_phase(eng_phase),
        .mode(mode), .ch_phase(ch_phase), .on_cycles(on_cycles),
        .inj_out(inj_a), .busy(busy_a), .overlap_err(ovl_a)
    );

    inj_sched #(.N_CH(N_CH), .PHASE_W(PW), .CNT_W(CW), .MIN_OFF(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .eng_phase(eng_phase),
        .mode(mode), .ch_phase(ch_phase), .on_cycles(on_cycles),
        .inj_out(inj_b), .busy(busy_b), .overlap_err(ovl_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: each channel's latest pulse as [start, start+len) high and
    // [start, rearm) busy, where cycle k is the cycle right after edge k.
    longint cyc;
    longint st  [2][N_CH];
    longint ln  [2][N_CH];
    longint ra  [2][N_CH];
    longint ov  [2][N_CH];
    bit     tg  [N_CH];
    int     min_off [2] = '{4, 0};
    logic [PW-1:0] chp [N_CH] = '{16'd100, 16'd200, 16'd500, 16'd500};
    logic [PW-1:0] phase_pool [6] = '{16'd100, 16'd200, 16'd500, 16'd777, 16'd100, 16'd500};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N_CH; i++) begin
                st[d][i] = 0;
                ln[d][i] = 0;
                ra[d][i] = 0;
                ov[d][i] = -1;
            end
        for (int i = 0; i < N_CH; i++) tg[i] = 1'b0;
    endtask

    task automatic model_edge();
        bit m, f;
        cyc++;
        if (rst) begin
            model_clear();
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            m = trigger && (eng_phase == chp[i]) && (on_cycles != 0);
            f = m && (!mode || tg[i]);
            if (m) tg[i] = !tg[i];
            if (f) begin
                for (int d = 0; d < 2; d++) begin
                    if (cyc >= ra[d][i]) begin
                        st[d][i] = cyc;
                        ln[d][i] = longint'(on_cycles);
                        ra[d][i] = cyc + longint'(on_cycles) + min_off[d];
                    end else begin
                        ov[d][i] = cyc;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_on(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < N_CH; i++)
            v[i] = (st[d][i] <= cyc) && (cyc < st[d][i] + ln[d][i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < N_CH; i++)
            v[i] = (st[d][i] <= cyc) && (cyc < ra[d][i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_ovl(input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < N_CH; i++)
            v[i] = (ov[d][i] == cyc);
        return v;
    endfunction

    initial begin
        logic [31:0] en_mask;
        rst       = 1'b1;
        en        = 1'b1;
        trigger   = 1'b0;
        mode      = 1'b0;
        eng_phase = '0;
        on_cycles = 32'd10;
        for (int i = 0; i < N_CH; i++) ch_phase[i*PW +: PW] = chp[i];
        cyc = 0;
        model_clear();

        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            model_edge();
            #1;
            en_mask = {28'd0, {N_CH{en}}};
            check("inj_a",  {28'd0, inj_a},  exp_on(0) & en_mask);
            check("busy_a", {28'd0, busy_a}, exp_busy(0));
            check("ovl_a",  {28'd0, ovl_a},  exp_ovl(0));
            check("inj_b",  {28'd0, inj_b},  exp_on(1) & en_mask);
            check("busy_b", {28'd0, busy_b}, exp_busy(1));
            check("ovl_b",  {28'd0, ovl_b},  exp_ovl(1));

            rst       = (n < 1) || ($urandom_range(0, 299) == 0);
            trigger   = ($urandom_range(0, 2) == 0);
            eng_phase = phase_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 199) == 0) mode = !mode;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 19))
                    0, 1:    on_cycles = 32'd0;
                    2, 3, 4: on_cycles = 32'd1;
                    default: on_cycles = 32'($urandom_range(2, 12));
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
